// File: rtl/cdc_pkg.sv
// Shared definitions for clock-domain-crossing receivers: default depth,
// a constant clog2 and the parameter-legality rule every CDC block uses.
`timescale 1ns/1ps
package cdc_pkg;

  localparam int DEFAULT_STAGES = 2;
  localparam int MIN_STAGES     = 2;
  localparam int MIN_FILTER     = 1;

  // Ceiling log2, usable in constant expressions; clog2(1) == 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

  function automatic bit params_legal(input int stages, input int filter);
    return (stages >= MIN_STAGES) && (filter >= MIN_FILTER);
  endfunction

endpackage

// File: rtl/sync_filter_chan.sv
// One receiving channel: synchronizer chain, persistence filter, filtered
// level flop and registered rise/fall pulses, plus a reject indication.
`timescale 1ns/1ps
module sync_filter_chan
  import cdc_pkg::*;
#(
  parameter int   STAGES    = DEFAULT_STAGES,
  parameter int   FILTER    = 4,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_B,
  input  logic reset,
  input  logic in_level,
  output logic b,
  output logic rise,
  output logic fall,
  output logic sync_mon,
  output logic reject
);

  // A one-cycle filter still needs a one-bit counter to keep the types legal.
  localparam int              CNT_W    = (FILTER > 1) ? clog2(FILTER) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_reg;

  logic [CNT_W-1:0] cnt_reg;
  logic             b_reg;
  logic             rise_reg;
  logic             fall_reg;
  logic             sync_last;
  logic             differ;
  logic             update;

  always_ff @(posedge clk_B) begin
    if (reset) begin
      sync_reg <= {STAGES{RESET_VAL}};
    end else begin
      sync_reg <= {sync_reg[STAGES-2:0], in_level};
    end
  end

  assign sync_last = sync_reg[STAGES-1];
  assign differ    = sync_last ^ b_reg;
  assign update    = differ && (cnt_reg == CNT_LAST);
  // Returning to the held level with a partial count means an excursion died.
  assign reject    = !differ && (cnt_reg != '0);

  always_ff @(posedge clk_B) begin
    if (reset) begin
      cnt_reg  <= '0;
      b_reg    <= RESET_VAL;
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
    end else begin
      rise_reg <= update & sync_last;
      fall_reg <= update & ~sync_last;
      if (update) begin
        b_reg   <= sync_last;
        cnt_reg <= '0;
      end else if (differ) begin
        cnt_reg <= cnt_reg + CNT_ONE;
      end else begin
        cnt_reg <= '0;
      end
    end
  end

  assign b        = b_reg;
  assign rise     = rise_reg;
  assign fall     = fall_reg;
  assign sync_mon = sync_last;

endmodule

// File: rtl/sync_filter_bank.sv
// Bank of WIDTH independent synchronize-and-deglitch channels with a shared
// saturating counter of clock edges on which any channel rejected a glitch.
`timescale 1ns/1ps
module sync_filter_bank
  import cdc_pkg::*;
#(
  parameter int   WIDTH     = 4,
  parameter int   STAGES    = DEFAULT_STAGES,
  parameter int   FILTER    = 4,
  parameter logic RESET_VAL = 1'b0,
  parameter int   GLITCH_W  = 8
) (
  input  logic                clk_B,
  input  logic                reset,
  input  logic [WIDTH-1:0]    IN,
  input  logic                glitch_clr,
  output logic [WIDTH-1:0]    B,
  output logic [WIDTH-1:0]    rise,
  output logic [WIDTH-1:0]    fall,
  output logic [WIDTH-1:0]    sync_mon,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  localparam logic [GLITCH_W-1:0] GLITCH_MAX = '1;
  localparam logic [GLITCH_W-1:0] GLITCH_ONE = GLITCH_W'(1);

  if (!params_legal(STAGES, FILTER)) begin : g_param_check
    $error("sync_filter_bank: STAGES must be >= 2 and FILTER must be >= 1");
  end

  logic [WIDTH-1:0]    reject_vec;
  logic [GLITCH_W-1:0] glitch_cnt_reg;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
    sync_filter_chan #(
      .STAGES    (STAGES),
      .FILTER    (FILTER),
      .RESET_VAL (RESET_VAL)
    ) u_chan (
      .clk_B    (clk_B),
      .reset    (reset),
      .in_level (IN[gi]),
      .b        (B[gi]),
      .rise     (rise[gi]),
      .fall     (fall[gi]),
      .sync_mon (sync_mon[gi]),
      .reject   (reject_vec[gi])
    );
  end

  // Clear beats a coincident reject; the count sticks at all-ones.
  always_ff @(posedge clk_B) begin
    if (reset || glitch_clr) begin
      glitch_cnt_reg <= '0;
    end else if ((|reject_vec) && (glitch_cnt_reg != GLITCH_MAX)) begin
      glitch_cnt_reg <= glitch_cnt_reg + GLITCH_ONE;
    end
  end

  assign glitch_cnt = glitch_cnt_reg;

endmodule

// File: tb/tb_sync_filter_bank.sv
// Directed bench for sync_filter_bank with a history-based reference model
// checked every cycle and literal expectations at the key edges.
`timescale 1ns/1ps
module tb_sync_filter_bank;

  localparam int   WIDTH     = 4;
  localparam int   STAGES    = 2;
  localparam int   FILTER    = 4;
  localparam int   GLITCH_W  = 8;
  localparam logic RESET_VAL = 1'b0;
  localparam int   GMAX      = (1 << GLITCH_W) - 1;

  logic                clk_A = 1'b0;
  logic                clk_B = 1'b0;
  logic                reset;
  logic                glitch_clr;
  logic [WIDTH-1:0]    IN;
  logic [WIDTH-1:0]    B;
  logic [WIDTH-1:0]    rise;
  logic [WIDTH-1:0]    fall;
  logic [WIDTH-1:0]    sync_mon;
  logic [GLITCH_W-1:0] glitch_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  bit model_on = 1'b0;
  bit stress_mon = 1'b0;

  always #5   clk_A = ~clk_A;
  always #7.5 clk_B = ~clk_B;

  sync_filter_bank #(
    .WIDTH     (WIDTH),
    .STAGES    (STAGES),
    .FILTER    (FILTER),
    .RESET_VAL (RESET_VAL),
    .GLITCH_W  (GLITCH_W)
  ) dut (
    .clk_B      (clk_B),
    .reset      (reset),
    .IN         (IN),
    .glitch_clr (glitch_clr),
    .B          (B),
    .rise       (rise),
    .fall       (fall),
    .sync_mon   (sync_mon),
    .glitch_cnt (glitch_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_B);
    #1;
  endtask

  // Reference model: the filtered level changes once the last FILTER
  // synchronized samples (since reset) all oppose it; a reject is a return
  // to the held level right after an opposing sample that did not qualify.
  logic [WIDTH-1:0] m_q[$];
  logic [WIDTH-1:0] m_hist[$];
  logic [WIDTH-1:0] m_b, m_rise, m_fall, m_sync;
  int               m_g;

  always @(posedge clk_B) begin
    logic [WIDTH-1:0] sm, upd, rej;
    int               n;
    if (reset) begin
      m_q.delete();
      for (int s = 0; s < STAGES; s++) m_q.push_back({WIDTH{RESET_VAL}});
      m_hist.delete();
      m_b    = {WIDTH{RESET_VAL}};
      m_rise = '0;
      m_fall = '0;
      m_g    = 0;
    end else begin
      sm = m_q[STAGES-1];
      m_hist.push_back(sm);
      n   = m_hist.size();
      upd = '0;
      rej = '0;
      for (int i = 0; i < WIDTH; i++) begin
        if (n >= FILTER) begin
          upd[i] = 1'b1;
          for (int k = n - FILTER; k < n; k++) begin
            if (m_hist[k][i] == m_b[i]) upd[i] = 1'b0;
          end
        end
        if (n >= 2 && sm[i] == m_b[i] && m_hist[n-2][i] != m_b[i]) rej[i] = 1'b1;
      end
      m_rise = upd & sm;
      m_fall = upd & ~sm;
      m_b    = (m_b & ~upd) | (sm & upd);
      if (glitch_clr) m_g = 0;
      else if (rej != '0 && m_g < GMAX) m_g++;
      m_q.push_front(IN);
      void'(m_q.pop_back());
      while (m_hist.size() > FILTER + 1) void'(m_hist.pop_front());
    end
    m_sync = m_q[STAGES-1];
  end

  always @(negedge clk_B) begin
    check("rise_fall_exclusive", 32'(rise & fall), 32'd0);
    if (model_on) begin
      check("model_B", 32'(B), 32'(m_b));
      check("model_rise", 32'(rise), 32'(m_rise));
      check("model_fall", 32'(fall), 32'(m_fall));
      check("model_sync_mon", 32'(sync_mon), 32'(m_sync));
      check("model_glitch_cnt", 32'(glitch_cnt), 32'(m_g));
    end
  end

  int               trans[WIDTH];
  int               pulses[WIDTH];
  logic [WIDTH-1:0] b_prev;

  always @(negedge clk_B) begin
    if (stress_mon) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (B[i] != b_prev[i]) trans[i]++;
        if (rise[i] || fall[i]) pulses[i]++;
      end
      b_prev = B;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int rise_at, fall_at, hits;
    logic [WIDTH-1:0] seen;
    bit pulse_seen;

    // Reset held for three edges with all inputs high.
    reset = 1'b1; glitch_clr = 1'b0; IN = 4'hF; model_on = 1'b1;
    for (int t = 1; t <= 3; t++) begin
      tick();
      check("reset_B", 32'(B), 32'h0);
      check("reset_sync_mon", 32'(sync_mon), 32'h0);
      check("reset_pulses", 32'(rise | fall), 32'h0);
      check("reset_glitch_cnt", 32'(glitch_cnt), 32'h0);
    end
    reset = 1'b0;
    for (int t = 1; t <= 7; t++) begin
      tick();
      if (t == 1) check("rel_sync_mon_e1", 32'(sync_mon), 32'h0);
      if (t == 2) check("rel_sync_mon_e2", 32'(sync_mon), 32'hF);
      if (t == 5) check("rel_B_e5", 32'(B), 32'h0);
      if (t == 6) begin
        check("rel_B_e6", 32'(B), 32'hF);
        check("rel_rise_e6", 32'(rise), 32'hF);
      end
      if (t == 7) check("rel_rise_e7", 32'(rise), 32'h0);
    end
    IN = 4'h0;
    repeat (8) tick();

    // Single rise on channel 0.
    IN = 4'b0001;
    for (int t = 1; t <= 7; t++) begin
      tick();
      if (t == 1) check("ch0_sync_mon_e1", 32'(sync_mon), 32'h0);
      if (t == 2) check("ch0_sync_mon_e2", 32'(sync_mon), 32'h1);
      if (t == 5) check("ch0_B_e5", 32'(B), 32'h0);
      if (t == 6) begin
        check("ch0_B_e6", 32'(B), 32'h1);
        check("ch0_rise_e6", 32'(rise), 32'h1);
      end
      if (t == 7) check("ch0_rise_e7", 32'(rise), 32'h0);
    end
    IN = 4'h0;
    repeat (8) tick();

    // Two-cycle glitch on channel 1: rejected on the fifth edge.
    IN[1] = 1'b1;
    tick(); tick();
    IN[1] = 1'b0;
    tick(); tick();
    check("glitch2_before", 32'(glitch_cnt), 32'd0);
    tick();
    check("glitch2_after", 32'(glitch_cnt), 32'd1);
    repeat (5) tick();
    check("glitch2_B", 32'(B), 32'h0);
    check("glitch2_once", 32'(glitch_cnt), 32'd1);

    // Three-cycle glitch: still rejected.
    IN[1] = 1'b1;
    repeat (3) tick();
    IN[1] = 1'b0;
    repeat (8) tick();
    check("glitch3_B", 32'(B), 32'h0);
    check("glitch3_cnt", 32'(glitch_cnt), 32'd2);

    // Four-cycle pulse passes: rise at edge 6, fall at edge 10.
    IN[1] = 1'b1;
    rise_at = -1; fall_at = -1;
    for (int t = 1; t <= 14; t++) begin
      tick();
      if (rise[1] && rise_at < 0) rise_at = t;
      if (fall[1] && fall_at < 0) fall_at = t;
      if (t == 4) IN[1] = 1'b0;
    end
    check("pulse4_rise_edge", 32'(rise_at), 32'd6);
    check("pulse4_fall_edge", 32'(fall_at), 32'd10);
    check("pulse4_no_reject", 32'(glitch_cnt), 32'd2);

    // Two channels change together.
    IN = 4'b1010;
    hits = 0; seen = '0; rise_at = -1;
    for (int t = 1; t <= 10; t++) begin
      tick();
      if (rise != '0) begin
        hits++;
        seen = rise;
        rise_at = t;
      end
    end
    check("multi_rise_value", 32'(seen), 32'hA);
    check("multi_rise_edges", 32'(hits), 32'd1);
    check("multi_rise_at", 32'(rise_at), 32'd6);
    IN = 4'b0000;
    hits = 0; seen = '0;
    for (int t = 1; t <= 10; t++) begin
      tick();
      if (fall != '0) begin
        hits++;
        seen = fall;
      end
    end
    check("multi_fall_value", 32'(seen), 32'hA);
    check("multi_fall_edges", 32'(hits), 32'd1);

    // Asynchronous stress: input changes land close to clk_B edges.
    model_on = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      trans[i] = 0;
      pulses[i] = 0;
    end
    b_prev = B;
    stress_mon = 1'b1;
    for (int n = 0; n < 200; n++) begin
      int idx;
      @(posedge clk_A);
      @(posedge clk_B);
      #(14.0 + real'($urandom_range(0, 1999)) / 1000.0);
      idx = int'($urandom_range(0, WIDTH - 1));
      IN[idx] = ~IN[idx];
    end
    repeat (7) tick();
    check("stress_settled", 32'(B), 32'(IN));
    stress_mon = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      check($sformatf("stress_pulses_bit%0d", i), 32'(pulses[i]), 32'(trans[i]));
    end

    // Resynchronise the model through a reset.
    IN = 4'h0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    model_on = 1'b1;
    check("post_stress_cnt", 32'(glitch_cnt), 32'd0);
    check("post_stress_B", 32'(B), 32'h0);

    // Saturation of the glitch counter.
    for (int n = 0; n < 300; n++) begin
      IN[3] = 1'b1;
      tick();
      IN[3] = 1'b0;
      repeat (3) tick();
    end
    repeat (4) tick();
    check("sat_value", 32'(glitch_cnt), 32'd255);
    IN[3] = 1'b1;
    tick();
    IN[3] = 1'b0;
    repeat (5) tick();
    check("sat_hold", 32'(glitch_cnt), 32'd255);

    // Clear on the same edge as a reject, from saturation and from zero.
    for (int r = 0; r < 3; r++) begin
      IN[3] = 1'b1;
      tick();
      IN[3] = 1'b0;
      tick(); tick();
      if (r != 1) glitch_clr = 1'b1;
      tick();
      glitch_clr = 1'b0;
      check($sformatf("clr_reject_round%0d", r), 32'(glitch_cnt), (r == 1) ? 32'd1 : 32'd0);
      repeat (3) tick();
    end

    // Reset while channel 2 is two counts into its filter.
    IN[2] = 1'b1;
    repeat (4) tick();
    check("midfilter_sync_mon", 32'(sync_mon), 32'h4);
    check("midfilter_B", 32'(B), 32'h0);
    reset = 1'b1;
    IN[2] = 1'b0;
    tick();
    reset = 1'b0;
    pulse_seen = 1'b0;
    for (int t = 1; t <= 8; t++) begin
      tick();
      if ((rise | fall) != '0) pulse_seen = 1'b1;
    end
    check("midfilter_B_after", 32'(B), 32'h0);
    check("midfilter_no_pulse", 32'(pulse_seen), 32'd0);
    check("midfilter_cnt", 32'(glitch_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_filter_bank.md
Name: sync_filter_bank

Overview:
- Parametrised successor to the two-flop single-bit synchronizer.
- Brings WIDTH asynchronous level inputs into the clk_B domain through a configurable-depth synchronizer chain per bit.
- Each synchronized bit then passes through a stability (deglitch) filter and a registered edge detector, producing clean levels plus single-cycle rise/fall pulses.
- A saturating counter reports rejected glitches for debug. The block sits at the receiving side of every asynchronous control/status crossing.

Parameters:
- WIDTH, 4: number of independent channels.
- STAGES, 2: synchronizer flops per channel; legal range is >=2.
- FILTER, 4: consecutive clk_B cycles a new synchronized value must persist before B changes; legal range is >=1.
- RESET_VAL, 0: reset level of every sync stage and of B, replicated across all bits.
- GLITCH_W, 8: width of glitch_cnt.

Ports:
- clk_B  input  1  sole clock; destination-domain clock.
- reset  input  1  synchronous, active-high reset.
- IN  input  WIDTH  asynchronous level inputs; no timing relation to clk_B.
- glitch_clr  input  1  synchronous clear of glitch_cnt.
- B  output  WIDTH  filtered, synchronized levels.
- rise  output  WIDTH  one-cycle pulse, high in the first cycle B[i] reads 1.
- fall  output  WIDTH  one-cycle pulse, high in the first cycle B[i] reads 0.
- sync_mon  output  WIDTH  last synchronizer stage, pre-filter; for monitoring.
- glitch_cnt  output  GLITCH_W  saturating count of clock edges on which at least one channel rejected a glitch.

Behaviour:
- Single clock (clk_B); reset is synchronous, active-high.
- Reset (sampled on a clk_B edge) sets the following; it overrides every other action on the same edge, including mid-filter:
  - all sync stages and B = RESET_VAL;
  - all filter counters = 0;
  - rise = fall = 0;
  - glitch_cnt = 0.
- Synchronizer:
  - Per bit, a shift chain of STAGES flops; IN feeds the first stage, sync_mon is the last.
  - No logic between stages.
  - Synthesis attribute ASYNC_REG on every stage.
- Filter, per channel i, with counter cnt of width clog2(FILTER), evaluated every edge:
  - sync_mon[i] != B[i] and cnt == FILTER-1: B[i] <= sync_mon[i], cnt <= 0, assert the edge pulse.
  - sync_mon[i] != B[i] and cnt < FILTER-1: cnt <= cnt+1.
  - sync_mon[i] == B[i]: cnt <= 0. If cnt was nonzero, this is a reject event.
  - FILTER = 1 gives zero extra hold: B follows sync_mon one edge later.
- Edge pulses:
  - rise[i] <= update_i & sync_mon[i]; fall[i] <= update_i & ~sync_mon[i].
  - Both are registered and aligned with the B change.
  - rise[i] and fall[i] are never both high.
  - Each pulse lasts exactly one cycle, even if the next toggle qualifies immediately. Minimum spacing between updates is FILTER cycles.
- Latency:
  - IN[i] change meeting setup before edge 1 appears on sync_mon at edge STAGES.
  - It appears on B/rise/fall at edge STAGES+FILTER.
  - With metastability, add 1 cycle of uncertainty.
- Glitch rejection:
  - Any sync_mon excursion shorter than FILTER cycles never reaches B.
  - Channels are independent; simultaneous qualifying changes on several bits update together on the same edge.
- glitch_cnt:
  - Increments by 1 on any edge with >=1 reject event across channels.
  - Saturates at 2^GLITCH_W-1 (no wrap).
  - glitch_clr zeroes it on the next edge; if glitch_clr and a reject occur on the same edge, clear wins (result 0).
- Illegal parameters (STAGES<2, FILTER<1) are flagged by an elaboration-time check.

Decomposition:
- Package cdc_pkg holds:
  - DEFAULT_STAGES = 2;
  - a clog2 helper function;
  - a parameter-legality check macro/function shared with future CDC blocks.
- Sub-module sync_filter_chan contains one channel: sync chain, filter counter, B flop, rise/fall flops, and a reject flag output.
- The top level instantiates WIDTH copies with generate, ORs the reject flags, and owns glitch_cnt.

Test Plan:
Bench configuration: WIDTH=4, STAGES=2, FILTER=4, clk_B period 15 ns, stimulus clocked from a 10 ns clk_A-style generator.
1. Reset: hold reset 3 edges with IN=4'hF -> B=0, sync_mon=0, rise=fall=0, glitch_cnt=0 throughout reset; after release, B=4'hF at edge 6 with rise=4'hF for one cycle.
2. Single rise: IN[0] 0->1 and held -> sync_mon[0]=1 at edge 2; B[0]=1 and rise[0]=1 at edge 6; rise[0]=0 at edge 7.
3. Glitch: IN[1] high for exactly 2 clk_B cycles -> B[1] stays 0, no rise/fall, glitch_cnt goes 0->1 exactly once. A 3-cycle pulse also rejected; a 4-cycle pulse passes (rise then fall 4 cycles apart).
4. Simultaneous channels: IN 4'b0000->4'b1010 -> rise=4'b1010 on a single edge; then ->4'b0000 -> fall=4'b1010 on a single edge.
5. Async stress: 200 random toggles at random ps offsets near clk_B edges, then IN held stable 7 cycles -> B==IN. Per-bit count of rise+fall equals number of B transitions; assertion rise&fall==0 every cycle.
6. Saturation/clear/reset:
   - 300 rejected glitches -> glitch_cnt=255 and holds.
   - glitch_clr coincident with a reject -> 0.
   - reset asserted when cnt=2 mid-filter -> B remains RESET_VAL, no pulse.
